gyro_tx_packet_sequencer: RTL and testbench

Sequences the 48-bit outbound gyro stream. It merges three 16-bit sample channels into one 48-bit word per sample slot and frames the words into packets of 64·2^packet_sel samples, with tlast on each packet's final word. It runs a fixed number of packets, or runs continuously until stopped, and drives the serializer's out_start_stop. It sits in the clock domain, upstream of the serializer's tx_fifo_t* AXI-stream port.

---
 rtl/gyro_tx_packet_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_gyro_tx_packet_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_tx_packet_sequencer.sv
// Merges three gyro sample channels into 48-bit words and frames them into
// packets of 64<<packet_sel samples for the serializer's AXI-stream input.
module gyro_tx_packet_sequencer #(
    parameter int unsigned DW    = 16,
    parameter int unsigned PKT_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [2:0]          i_packet_sel,
    input  logic [PKT_W-1:0]    i_num_packets,
    input  logic [2:0]          i_ch_en,
    input  logic [DW-1:0]       i_s0_tdata,
    input  logic [DW-1:0]       i_s1_tdata,
    input  logic [DW-1:0]       i_s2_tdata,
    input  logic                i_s0_tvalid,
    input  logic                i_s1_tvalid,
    input  logic                i_s2_tvalid,
    output logic                o_s0_tready,
    output logic                o_s1_tready,
    output logic                o_s2_tready,
    output logic [3*DW-1:0]     o_m_tdata,
    output logic                o_m_tvalid,
    input  logic                i_m_tready,
    output logic                o_m_tlast,
    output logic                o_out_start_stop,
    output logic                o_busy,
    output logic                o_packet_done,
    output logic [PKT_W-1:0]    o_packets_sent,
    output logic                o_cfg_err
);

    localparam int unsigned IDX_W = 13;
    localparam int unsigned OW    = 3 * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_packet_sel;
    logic [PKT_W-1:0]   r_num_packets;
    logic [2:0]         r_ch_en;
    logic [IDX_W-1:0]   r_sample_idx;
    logic               r_stop_pending;
    logic [PKT_W-1:0]   r_packets_sent;
    logic [OW-1:0]      r_m_tdata;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic               r_packet_done;
    logic               r_cfg_err;
    logic               r_active;

    logic [2:0]         w_valid_vec;
    logic               w_all_valid;
    logic               w_out_free;
    logic               w_boundary_stop;
    logic               w_load;
    logic [IDX_W-1:0]   w_idx_last;
    logic               w_is_last;
    logic [PKT_W-1:0]   w_sent_inc;
    logic               w_run_done;
    logic               w_cfg_ok;
    logic               w_accept_start;
    logic [2:0]         w_tready;
    logic [OW-1:0]      w_word;

    // A word is loaded only when every enabled channel has data and the output slot is free.
    assign w_valid_vec     = {i_s2_tvalid, i_s1_tvalid, i_s0_tvalid};
    assign w_all_valid     = &(w_valid_vec | ~r_ch_en);
    assign w_out_free      = !r_m_tvalid || i_m_tready;
    assign w_boundary_stop = r_stop_pending && (r_sample_idx == '0);
    assign w_load          = (r_state == S_RUN) && w_all_valid && w_out_free && !w_boundary_stop;

    // Last index of a packet; the 8192-sample case wraps the 13-bit shift to 0 and then to all-ones.
    assign w_idx_last = (IDX_W'(64) << r_packet_sel) - IDX_W'(1);
    assign w_is_last  = (r_sample_idx == w_idx_last);
    assign w_sent_inc = (&r_packets_sent) ? r_packets_sent : r_packets_sent + PKT_W'(1);
    assign w_run_done = w_load && w_is_last &&
                        (r_stop_pending || ((r_num_packets != '0) && (w_sent_inc == r_num_packets)));

    assign w_cfg_ok       = (i_ch_en != 3'b000);
    assign w_accept_start = (r_state == S_IDLE) && i_start && w_cfg_ok;

    assign w_word = {r_ch_en[2] ? i_s2_tdata : DW'(0),
                     r_ch_en[1] ? i_s1_tdata : DW'(0),
                     r_ch_en[0] ? i_s0_tdata : DW'(0)};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_run_done || w_boundary_stop) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Only enabled channels are handshaken, and only on a load.
    always_comb begin
        w_tready = 3'b000;
        if (w_load) begin
            w_tready = r_ch_en;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_packet_sel   <= 3'd0;
            r_num_packets  <= '0;
            r_ch_en        <= 3'b000;
            r_sample_idx   <= '0;
            r_stop_pending <= 1'b0;
            r_packets_sent <= '0;
            r_m_tdata      <= '0;
            r_m_tvalid     <= 1'b0;
            r_m_tlast      <= 1'b0;
            r_packet_done  <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_active       <= 1'b0;
        end else begin
            r_packet_done <= r_m_tvalid && i_m_tready && r_m_tlast;
            r_cfg_err     <= (r_state == S_IDLE) && i_start && !w_cfg_ok;
            r_active      <= (w_state_nxt != S_IDLE);

            if (w_accept_start) begin
                r_packet_sel   <= i_packet_sel;
                r_num_packets  <= i_num_packets;
                r_ch_en        <= i_ch_en;
                r_sample_idx   <= '0;
                r_packets_sent <= '0;
                r_stop_pending <= 1'b0;
            end

            if ((r_state == S_RUN) && i_stop) begin
                r_stop_pending <= 1'b1;
            end

            if (w_load) begin
                r_m_tdata    <= w_word;
                r_m_tlast    <= w_is_last;
                r_m_tvalid   <= 1'b1;
                r_sample_idx <= w_is_last ? '0 : r_sample_idx + IDX_W'(1);
                if (w_is_last) begin
                    r_packets_sent <= w_sent_inc;
                end
            end else if (i_m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign o_s0_tready      = w_tready[0];
    assign o_s1_tready      = w_tready[1];
    assign o_s2_tready      = w_tready[2];
    assign o_m_tdata        = r_m_tdata;
    assign o_m_tvalid       = r_m_tvalid;
    assign o_m_tlast        = r_m_tlast;
    assign o_out_start_stop = r_active;
    assign o_busy           = r_active;
    assign o_packet_done    = r_packet_done;
    assign o_packets_sent   = r_packets_sent;
    assign o_cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_gyro_tx_packet_sequencer.sv
// Directed bench for gyro_tx_packet_sequencer: framing, masking, back-pressure,
// graceful stop, starvation, config error and mid-run reset.
module tb_gyro_tx_packet_sequencer;

    localparam int unsigned DW    = 16;
    localparam int unsigned PKT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop;
    logic [2:0]        packet_sel;
    logic [PKT_W-1:0]  num_packets;
    logic [2:0]        ch_en;
    logic [DW-1:0]     s0_tdata, s1_tdata, s2_tdata;
    logic              s0_tvalid, s1_tvalid, s2_tvalid;
    logic              s0_tready, s1_tready, s2_tready;
    logic [3*DW-1:0]   m_tdata;
    logic              m_tvalid, m_tready, m_tlast;
    logic              out_start_stop, busy, packet_done, cfg_err;
    logic [PKT_W-1:0]  packets_sent;

    always #5 clk = ~clk;

    gyro_tx_packet_sequencer #(.DW(DW), .PKT_W(PKT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_packet_sel(packet_sel), .i_num_packets(num_packets), .i_ch_en(ch_en),
        .i_s0_tdata(s0_tdata), .i_s1_tdata(s1_tdata), .i_s2_tdata(s2_tdata),
        .i_s0_tvalid(s0_tvalid), .i_s1_tvalid(s1_tvalid), .i_s2_tvalid(s2_tvalid),
        .o_s0_tready(s0_tready), .o_s1_tready(s1_tready), .o_s2_tready(s2_tready),
        .o_m_tdata(m_tdata), .o_m_tvalid(m_tvalid), .i_m_tready(m_tready), .o_m_tlast(m_tlast),
        .o_out_start_stop(out_start_stop), .o_busy(busy), .o_packet_done(packet_done),
        .o_packets_sent(packets_sent), .o_cfg_err(cfg_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counting source: every channel presents its own tag plus the sample number.
    logic [13:0] src_cnt = '0;
    logic        src_clr;
    logic        force_data;
    assign s0_tdata = force_data ? 16'h1111 : {2'b00, src_cnt};
    assign s1_tdata = 16'h4000 | {2'b00, src_cnt};
    assign s2_tdata = force_data ? 16'h2222 : (16'h8000 | {2'b00, src_cnt});

    always @(posedge clk) begin
        if (src_clr) src_cnt <= '0;
        else if (s0_tready || s1_tready || s2_tready) src_cnt <= src_cnt + 14'd1;
    end

    // Output monitor: checks each accepted word and AXI hold during stalls.
    int          w = 0, last_cnt = 0, pd_cnt = 0, exp_n = 64;
    logic        chk_mask = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_last;
    logic [47:0] prev_data, exp_d;
    logic [15:0] e;

    always @(negedge clk) begin
        if (src_clr) begin
            w = 0; last_cnt = 0; pd_cnt = 0;
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", 64'(m_tdata), 64'(prev_data));
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
        end
        if (chk_mask) chk("s1_tready_masked", 64'(s1_tready), 64'd0);
        if (packet_done) pd_cnt++;
        if (m_tvalid && m_tready) begin
            e = 16'(w);
            exp_d = chk_mask ? 48'h2222_0000_1111 : {16'h8000 | e, 16'h4000 | e, e};
            chk("word_data", 64'(m_tdata), 64'(exp_d));
            chk("word_tlast", 64'(m_tlast), 64'((w % exp_n) == exp_n - 1));
            if (m_tlast) last_cnt++;
            w++;
        end
        prev_stall = m_tvalid && !m_tready && !rst;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
    end

    logic bp = 1'b0;
    int   cyc, snap;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp) m_tready = !m_tready;
    endtask

    task automatic clear_src();
        src_clr = 1'b1;
        tick();
        src_clr = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] sel, input logic [PKT_W-1:0] num, input logic [2:0] en);
        packet_sel  = sel;
        num_packets = num;
        ch_en       = en;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        packet_sel = 3'd0; num_packets = '0; ch_en = 3'b000;
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; s2_tvalid = 1'b1;
        m_tready = 1'b1; src_clr = 1'b1; force_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tready", 64'({s2_tready, s1_tready, s0_tready}), 64'd0);
        chk("rst_busy_oss", 64'({busy, out_start_stop}), 64'd0);
        chk("rst_pd_cfg", 64'({packet_done, cfg_err}), 64'd0);
        chk("rst_packets_sent", 64'(packets_sent), 64'd0);
        rst = 1'b0;
        tick();
        src_clr = 1'b0;

        // Fixed-length: 2 packets of 64, full throughput.
        clear_src();
        exp_n = 64;
        start_run(3'd0, 16'd2, 3'b111);
        chk("start_busy", 64'({busy, out_start_stop}), 64'b11);
        chk("first_load_ready", 64'({s2_tready, s1_tready, s0_tready}), 64'b111);
        wait_idle(1000, cyc);
        chk("fixed_run_cycles", 64'(cyc), 64'd129);
        chk("fixed_oss_low", 64'(out_start_stop), 64'd0);
        tick();
        chk("fixed_words", 64'(w), 64'd128);
        chk("fixed_tlasts", 64'(last_cnt), 64'd2);
        chk("fixed_pkt_done", 64'(pd_cnt), 64'd2);
        chk("fixed_packets_sent", 64'(packets_sent), 64'd2);
        chk("fixed_tvalid_low", 64'(m_tvalid), 64'd0);

        // Masked channel 1 with constant data on channels 0 and 2.
        clear_src();
        s1_tvalid = 1'b0; force_data = 1'b1; chk_mask = 1'b1;
        start_run(3'd0, 16'd1, 3'b101);
        tick(); tick();
        chk("mask_tvalid", 64'(m_tvalid), 64'd1);
        chk("mask_tdata", 64'(m_tdata), 64'h2222_0000_1111);
        wait_idle(1000, cyc);
        tick();
        chk_mask = 1'b0; s1_tvalid = 1'b1; force_data = 1'b0;
        chk("mask_words", 64'(w), 64'd64);
        chk("mask_tlasts", 64'(last_cnt), 64'd1);

        // Back-pressure: m_tready toggles every cycle.
        clear_src();
        start_run(3'd0, 16'd2, 3'b111);
        bp = 1'b1;
        wait_idle(2000, cyc);
        bp = 1'b0; m_tready = 1'b1;
        tick();
        chk("bp_words", 64'(w), 64'd128);
        chk("bp_tlasts", 64'(last_cnt), 64'd2);
        chk("bp_packets_sent", 64'(packets_sent), 64'd2);

        // Graceful stop in continuous mode, ten words into packet 3.
        clear_src();
        start_run(3'd0, 16'd0, 3'b111);
        cyc = 0;
        while (w < 138 && cyc < 2000) begin tick(); cyc++; end
        chk("stop_reached", 64'(w >= 138), 64'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(2000, cyc);
        chk("stop_oss_low", 64'(out_start_stop), 64'd0);
        tick();
        chk("stop_words", 64'(w), 64'd192);
        chk("stop_tlasts", 64'(last_cnt), 64'd3);
        chk("stop_packets_sent", 64'(packets_sent), 64'd3);

        // Starved channel 2 mid-packet.
        clear_src();
        start_run(3'd0, 16'd1, 3'b111);
        cyc = 0;
        while (w < 20 && cyc < 500) begin tick(); cyc++; end
        s2_tvalid = 1'b0;
        tick(); tick();
        snap = w;
        for (int i = 0; i < 20; i++) begin
            chk("starve_tready", 64'({s2_tready, s1_tready, s0_tready}), 64'd0);
            chk("starve_tvalid", 64'(m_tvalid), 64'd0);
            tick();
        end
        chk("starve_no_loads", 64'(w), 64'(snap));
        s2_tvalid = 1'b1;
        wait_idle(1000, cyc);
        tick();
        chk("starve_words", 64'(w), 64'd64);
        chk("starve_tlasts", 64'(last_cnt), 64'd1);

        // Config error: start with no channels enabled.
        ch_en = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        chk("cfg_err_busy", 64'(busy), 64'd0);
        tick();
        chk("cfg_err_clear", 64'({cfg_err, busy}), 64'd0);

        // Start and stop together in IDLE: stop is discarded, full packet runs.
        clear_src();
        stop = 1'b1;
        start_run(3'd0, 16'd1, 3'b111);
        stop = 1'b0;
        wait_idle(1000, cyc);
        tick();
        chk("startstop_words", 64'(w), 64'd64);

        // Reset mid-packet, then a fresh run restarts the sample index.
        clear_src();
        exp_n = 128;
        start_run(3'd1, 16'd0, 3'b111);
        cyc = 0;
        while (w < 30 && cyc < 500) begin tick(); cyc++; end
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_busy_oss", 64'({busy, out_start_stop}), 64'd0);
        tick();
        rst = 1'b0;
        clear_src();
        exp_n = 64;
        start_run(3'd0, 16'd1, 3'b111);
        wait_idle(1000, cyc);
        tick();
        chk("rerun_words", 64'(w), 64'd64);
        chk("rerun_tlasts", 64'(last_cnt), 64'd1);
        chk("rerun_packets_sent", 64'(packets_sent), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
